// File: rtl/hc_run_sequencer_pkg.sv
// Shared types and default constants for the One-Max hill-climbing block:
// sequencer state encoding, default widths and the datapath enable divider.
package hc_pkg;

   localparam int unsigned HC_N_BITS  = 1024;
   localparam int unsigned HC_FIT_W   = 12;
   localparam int unsigned HC_CLK_DIV = 250000;

   typedef logic [HC_FIT_W-1:0] fitness_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_ARM,
      ST_RUN,
      ST_CAPTURE,
      ST_FINISH
   } hc_seq_state_t;

endpackage

// File: rtl/hc_run_sequencer_if.sv
// Handshake bundle between the run sequencer (master) and the
// hill_climbing datapath (slave).
interface hc_run_sequencer_if #(
   parameter int unsigned N_BITS = hc_pkg::HC_N_BITS,
   parameter int unsigned FIT_W  = hc_pkg::HC_FIT_W
);
   logic              hc_clk_enable;
   logic              hc_start;
   logic              hc_running;
   logic              hc_done;
   logic [FIT_W-1:0]  hc_fitness;
   logic [N_BITS-1:0] hc_solution;

   modport master (
      output hc_clk_enable, hc_start,
      input  hc_running, hc_done, hc_fitness, hc_solution
   );

   modport slave (
      input  hc_clk_enable, hc_start,
      output hc_running, hc_done, hc_fitness, hc_solution
   );
endinterface

// File: rtl/hc_run_sequencer_clk_en_div.sv
// Free-running divider: one-cycle enable every CLK_DIV system clocks,
// high while the count sits at CLK_DIV-1.
module clk_en_div
   import hc_pkg::*;
#(
   parameter int unsigned CLK_DIV = HC_CLK_DIV
) (
   input  logic CLOCK_50,
   input  logic rst_n,
   output logic clk_enable
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   // Count 0..CLK_DIV-1; the enable is registered one count early so it
   // coincides with count CLK_DIV-1.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         clk_enable <= 1'b0;
      end else begin
         if (cnt == CNT_W'(CLK_DIV - 1))
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
         clk_enable <= (cnt == CNT_W'(CLK_DIV - 2));
      end
   end

endmodule

// File: rtl/hc_run_sequencer.sv
// Multi-run controller for hill_climbing: launches N_RUNS climbs per
// request, tracks the best fitness/solution, and times out stuck runs.
module hc_run_sequencer
   import hc_pkg::*;
#(
   parameter int unsigned N_BITS        = HC_N_BITS,
   parameter int unsigned FIT_W         = HC_FIT_W,
   parameter int unsigned N_RUNS        = 8,
   parameter int unsigned CLK_DIV       = HC_CLK_DIV,
   parameter int unsigned TIMEOUT_TICKS = 65535
) (
   input  logic               CLOCK_50,
   input  logic               rst_n,
   input  logic               start_req,
   input  logic               abort,
   hc_run_sequencer_if.master hc,
   output logic               busy,
   output logic               seq_done,
   output logic [FIT_W-1:0]   best_fitness,
   output logic [N_BITS-1:0]  best_solution,
   output logic [7:0]         best_run,
   output logic [7:0]         run_idx,
   output logic [7:0]         timeout_cnt
);

   hc_seq_state_t state;
   logic [15:0]   tick_cnt;
   logic          timed_out;
   logic          clk_en;

   clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
      .CLOCK_50   (CLOCK_50),
      .rst_n      (rst_n),
      .clk_enable (clk_en)
   );

   assign hc.hc_clk_enable = clk_en;

   // Sequencer FSM with registered control outputs and best-value tracking.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         hc.hc_start   <= 1'b0;
         busy          <= 1'b0;
         seq_done      <= 1'b0;
         best_fitness  <= '0;
         best_solution <= '0;
         best_run      <= '0;
         run_idx       <= '0;
         timeout_cnt   <= '0;
         tick_cnt      <= '0;
         timed_out     <= 1'b0;
      end else begin
         hc.hc_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_req) begin
                  state         <= ST_LAUNCH;
                  hc.hc_start   <= 1'b1;
                  busy          <= 1'b1;
                  seq_done      <= 1'b0;
                  best_fitness  <= '0;
                  best_solution <= '0;
                  best_run      <= '0;
                  run_idx       <= '0;
                  timeout_cnt   <= '0;
               end
            end
            ST_LAUNCH: begin
               tick_cnt <= '0;
               state    <= abort ? ST_FINISH : ST_ARM;
            end
            ST_ARM: begin
               if (clk_en && tick_cnt != '1)
                  tick_cnt <= tick_cnt + 16'd1;
               if (abort)
                  state <= ST_FINISH;
               else if (hc.hc_running && !hc.hc_done)
                  state <= ST_RUN;
            end
            ST_RUN: begin
               if (clk_en && tick_cnt != '1)
                  tick_cnt <= tick_cnt + 16'd1;
               // done wins over a simultaneous timeout
               if (abort) begin
                  state <= ST_FINISH;
               end else if (hc.hc_done) begin
                  state     <= ST_CAPTURE;
                  timed_out <= 1'b0;
               end else if (tick_cnt >= 16'(TIMEOUT_TICKS)) begin
                  state     <= ST_CAPTURE;
                  timed_out <= 1'b1;
               end
            end
            ST_CAPTURE: begin
               // run 0 seeds the best; later runs need a strictly better fitness
               if (run_idx == 8'd0 || hc.hc_fitness > best_fitness) begin
                  best_fitness  <= hc.hc_fitness;
                  best_solution <= hc.hc_solution;
                  best_run      <= run_idx;
               end
               if (timed_out && timeout_cnt != 8'hFF)
                  timeout_cnt <= timeout_cnt + 8'd1;
               if (abort) begin
                  state <= ST_FINISH;
               end else if (run_idx < 8'(N_RUNS - 1)) begin
                  state       <= ST_LAUNCH;
                  run_idx     <= run_idx + 8'd1;
                  hc.hc_start <= 1'b1;
               end else begin
                  state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               state    <= ST_IDLE;
               busy     <= 1'b0;
               seq_done <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hc_run_sequencer.sv
// Scoreboard bench for hc_run_sequencer with a scripted hill_climbing model.
module tb_hc_run_sequencer;

   localparam int unsigned NB  = 16;
   localparam int unsigned FW  = 5;
   localparam int unsigned NR  = 3;

   typedef struct {
      int fit;
      int run;
      int idx;
      int tmo;
      int starts;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_req = 1'b0;
   logic          abort = 1'b0;
   logic          busy, seq_done;
   logic [FW-1:0] best_fitness;
   logic [NB-1:0] best_solution;
   logic [7:0]    best_run, run_idx, timeout_cnt;

   int   vectors = 0;
   int   miscompares = 0;
   int   n_starts = 0;
   int   run_base = 0;
   int   fit_script [NR];
   bit   hang_script [NR];
   exp_t exp_q [$];

   hc_run_sequencer_if #(.N_BITS(NB), .FIT_W(FW)) hc ();

   hc_run_sequencer #(
      .N_BITS(NB), .FIT_W(FW), .N_RUNS(NR), .CLK_DIV(4), .TIMEOUT_TICKS(10)
   ) dut (
      .CLOCK_50      (clk),
      .rst_n         (rst_n),
      .start_req     (start_req),
      .abort         (abort),
      .hc            (hc),
      .busy          (busy),
      .seq_done      (seq_done),
      .best_fitness  (best_fitness),
      .best_solution (best_solution),
      .best_run      (best_run),
      .run_idx       (run_idx),
      .timeout_cnt   (timeout_cnt)
   );

   always #5 clk = ~clk;

   function automatic int exp_sol(int run, int fit);
      return 32'hA000 | (run << 8) | fit;
   endfunction

   task automatic check(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Behavioural hill_climbing: fitness appears 3 cycles into a run,
   // done 6 cycles in unless the run is scripted to hang.
   initial begin : model
      int cur;
      int mcnt;
      cur = 0;
      mcnt = 0;
      hc.hc_running = 1'b0;
      hc.hc_done = 1'b0;
      hc.hc_fitness = '0;
      hc.hc_solution = '0;
      forever begin
         @(posedge clk);
         if (hc.hc_start) begin
            cur = n_starts - run_base;
            if (cur > NR - 1) cur = NR - 1;
            n_starts++;
            mcnt = 0;
            hc.hc_running  <= 1'b1;
            hc.hc_done     <= 1'b0;
            hc.hc_fitness  <= '0;
            hc.hc_solution <= '0;
         end else if (hc.hc_running) begin
            mcnt++;
            if (mcnt == 3) begin
               hc.hc_fitness  <= FW'(fit_script[cur]);
               hc.hc_solution <= NB'(exp_sol(cur, fit_script[cur]));
            end
            if (mcnt == 6 && !hang_script[cur]) begin
               hc.hc_done    <= 1'b1;
               hc.hc_running <= 1'b0;
            end
         end
      end
   end

   // Monitor: each rising seq_done retires one expected sequence result.
   initial begin : monitor
      logic prev_sd;
      exp_t e;
      prev_sd = 1'b0;
      forever begin
         @(negedge clk);
         if (seq_done && !prev_sd) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_seq_done: got a completion, expected none");
            end else begin
               e = exp_q.pop_front();
               check("best_fitness", int'(best_fitness), e.fit);
               check("best_run", int'(best_run), e.run);
               check("best_solution", int'(best_solution), exp_sol(e.run, e.fit));
               check("run_idx", int'(run_idx), e.idx);
               check("timeout_cnt", int'(timeout_cnt), e.tmo);
               check("hc_start_count", n_starts - run_base, e.starts);
               check("busy_at_done", int'(busy), 0);
            end
         end
         prev_sd = seq_done;
      end
   end

   task automatic check_all_zero(string tag);
      check({tag, "_hc_clk_enable"}, int'(hc.hc_clk_enable), 0);
      check({tag, "_hc_start"}, int'(hc.hc_start), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_seq_done"}, int'(seq_done), 0);
      check({tag, "_best_fitness"}, int'(best_fitness), 0);
      check({tag, "_best_solution"}, int'(best_solution), 0);
      check({tag, "_best_run"}, int'(best_run), 0);
      check({tag, "_run_idx"}, int'(run_idx), 0);
      check({tag, "_timeout_cnt"}, int'(timeout_cnt), 0);
   endtask

   task automatic set_script(int f0, int f1, int f2, bit h0, bit h1, bit h2);
      fit_script[0] = f0; fit_script[1] = f1; fit_script[2] = f2;
      hang_script[0] = h0; hang_script[1] = h1; hang_script[2] = h2;
      run_base = n_starts;
   endtask

   // Pulse start_req and check the accept response one cycle later.
   task automatic do_start();
      @(negedge clk);
      start_req = 1'b1;
      @(negedge clk);
      start_req = 1'b0;
      check("launch_hc_start", int'(hc.hc_start), 1);
      check("launch_busy", int'(busy), 1);
      check("launch_seq_done", int'(seq_done), 0);
      @(negedge clk);
      check("hc_start_width", int'(hc.hc_start), 0);
   endtask

   task automatic wait_done(string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (seq_done) seen = 1'b1;
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got no seq_done in 3000 cycles, expected seq_done", tag);
      end
      @(negedge clk);
   endtask

   task automatic wait_starts(int n);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         @(negedge clk);
         if (n_starts - run_base >= n) seen = 1'b1;
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_starts: got %0d starts, expected %0d", n_starts - run_base, n);
      end
   endtask

   initial begin : stimulus
      int first;
      for (int i = 0; i < NR; i++) begin
         fit_script[i] = 0;
         hang_script[i] = 1'b0;
      end

      // Reset state
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Divider: period 4, one-cycle high
      first = -1;
      for (int i = 0; i < 8 && first < 0; i++) begin
         @(negedge clk);
         if (hc.hc_clk_enable) first = i;
      end
      check("clk_en_found", int'(first >= 0), 1);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         check("clk_en_pattern", int'(hc.hc_clk_enable), int'((i % 4) == 0));
      end

      // Fitness 5, 9, 7; a start_req while busy is ignored
      set_script(5, 9, 7, 0, 0, 0);
      exp_q.push_back('{fit: 9, run: 1, idx: 2, tmo: 0, starts: 3});
      do_start();
      repeat (10) @(negedge clk);
      start_req = 1'b1;
      @(negedge clk);
      start_req = 1'b0;
      wait_done("seq_a");

      // Ties: earliest run wins
      set_script(6, 6, 6, 0, 0, 0);
      exp_q.push_back('{fit: 6, run: 0, idx: 2, tmo: 0, starts: 3});
      do_start();
      wait_done("seq_tie");

      // Run 1 hangs and times out; its sampled fitness still counts
      set_script(3, 8, 2, 0, 1, 0);
      exp_q.push_back('{fit: 8, run: 1, idx: 2, tmo: 1, starts: 3});
      do_start();
      wait_done("seq_timeout");

      // Abort during run 1
      set_script(4, 12, 5, 0, 1, 0);
      exp_q.push_back('{fit: 4, run: 0, idx: 1, tmo: 0, starts: 2});
      do_start();
      wait_starts(2);
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done("seq_abort");
      repeat (20) @(negedge clk);
      check("abort_no_third_start", n_starts - run_base, 2);
      check("abort_busy", int'(busy), 0);
      check("abort_seq_done", int'(seq_done), 1);

      // Reset mid-run, then a clean sequence
      set_script(5, 9, 7, 0, 0, 0);
      do_start();
      wait_starts(1);
      repeat (4) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrun_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      set_script(5, 9, 7, 0, 0, 0);
      exp_q.push_back('{fit: 9, run: 1, idx: 2, tmo: 0, starts: 3});
      do_start();
      wait_done("seq_after_reset");

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hc_run_sequencer.md
# hc_run_sequencer

Multi-run controller for the `hill_climbing` datapath in the One-Max design. On one start request it launches `N_RUNS` consecutive climbs, keeps the best fitness and solution across runs, and enforces a per-run timeout. It also generates the datapath clock-enable. It sits between the top-level switch/LED logic and `hill_climbing`, replacing the direct start-pulse connection.

## Interface
- `N_BITS`, default 1024: solution width.
- `FIT_W`, default 12: fitness width; must be at least clog2(N_BITS+1).
- `N_RUNS`, default 8: climbs per request; range 1..255.
- `CLK_DIV`, default 250000: CLOCK_50 cycles per datapath enable; must be ≥2.
- `TIMEOUT_TICKS`, default 65535: enable ticks allowed per run; must be ≥1.
- `CLOCK_50` input 1: system clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start_req` input 1: one-cycle request pulse. It is ignored while `busy`.
- `abort` input 1: level. It ends the sequence at the next cycle.
- `hc_clk_enable` output 1: datapath enable.
- `hc_start` output 1: one-cycle launch pulse to `hill_climbing`.
- `hc_running` input 1: datapath running flag.
- `hc_done` input 1: datapath done flag. It is a level, held until the next `hc_start`.
- `hc_fitness` input FIT_W: current best fitness of the datapath.
- `hc_solution` input N_BITS: current best solution of the datapath.
- `busy` output 1: sequence in progress.
- `seq_done` output 1: high from sequence end until the next accepted `start_req`.
- `best_fitness` output FIT_W: best fitness over completed runs.
- `best_solution` output N_BITS: solution that produced `best_fitness`.
- `best_run` output 8: index (0-based) of the run that produced `best_fitness`.
- `run_idx` output 8: index of the current or last run.
- `timeout_cnt` output 8: number of runs ended by timeout in this sequence. It saturates at 255.

## Operation
- States and transitions:
  - IDLE: on `start_req`, go to LAUNCH.
  - LAUNCH: assert `hc_start` for exactly one cycle, then go to ARM.
  - ARM: wait until `hc_running`=1 and `hc_done`=0, then go to RUN.
  - RUN: go to CAPTURE when `hc_done`=1, or when the run tick counter reaches TIMEOUT_TICKS.
  - CAPTURE: one cycle; go to LAUNCH if `run_idx` < N_RUNS-1, else go to FINISH.
  - FINISH: go to IDLE.
- Accepting `start_req` in IDLE clears `best_fitness`, `best_solution`, `best_run`, `run_idx`, `timeout_cnt` and `seq_done`.
- CAPTURE comparison:
  - Replace the best values with the sampled ones when `hc_fitness` > `best_fitness` (unsigned, strict).
  - Run 0 always replaces them.
  - On ties, the earlier run wins.
- Timeout path:
  - CAPTURE still samples `hc_fitness` and `hc_solution`.
  - `timeout_cnt` increments, saturating at 255.
  - `hc_done` arriving on the same cycle as the timeout counts as done, not as a timeout.
- CAPTURE→LAUNCH increments `run_idx`. The final CAPTURE does not increment it, so at the end `run_idx` = N_RUNS-1.
- `abort` in any non-IDLE state goes to FINISH on the next cycle. Best values from completed CAPTUREs are kept, and `seq_done` is set.
- `hc_clk_enable` uses a free-running divider counting 0..CLK_DIV-1. The enable is high for the single cycle in which the count is CLK_DIV-1, independent of state.
- The run tick counter is 16 bits. It clears in LAUNCH and increments on `hc_clk_enable` while in ARM or RUN.

## Timing
- Reset values:
  - All outputs are 0.
  - `hc_clk_enable` is 0, and the divider count is 0.
  - State is IDLE.
- `start_req` at cycle t: LAUNCH at t+1, so `hc_start` is high during cycle t+1 only.
- `busy` is registered. It is high from the cycle after an accepted `start_req` through FINISH, and low in IDLE.
- RUN exits the cycle after `hc_done` is sampled high. CAPTURE registers the outputs, so the new `best_*` values are visible one cycle after CAPTURE.
- The next `hc_start` comes at CAPTURE+1. The gap between runs is therefore 2 cycles after done, plus the ARM wait.
- `seq_done` rises the cycle after FINISH, together with `busy` falling.
- ARM waits indefinitely for `hc_running`, but its ticks count against the timeout, so the run can still time out.
- `start_req` arriving in FINISH is ignored.
- A reset mid-operation returns immediately to the reset values, and `hc_start` drops asynchronously.

## Structure
- Package `hc_pkg`:
  - State enum `hc_seq_state_t`.
  - Default constants for N_BITS, FIT_W and CLK_DIV.
  - Type `fitness_t` = logic[FIT_W-1:0].
- The top-level timer and `hill_climbing` consume these constants too.
- Sub-module `clk_en_div` (parameter CLK_DIV) is a natural split: it is the divider producing `hc_clk_enable`. The FSM and the best-value registers stay in `hc_run_sequencer`.

## Test plan
The bench sets CLK_DIV=4, N_RUNS=3, TIMEOUT_TICKS=10, and uses a behavioural `hill_climbing` model with a scripted fitness per run.

- Fitness per run 5, 9, 7 → `best_fitness`=9, `best_run`=1, `run_idx`=2, `timeout_cnt`=0, `seq_done`=1, and exactly 3 `hc_start` pulses.
- Ties 6, 6, 6 → `best_run`=0.
- Run 1 never asserts done → CAPTURE after 10 ticks, then `timeout_cnt`=1, and run 2 is launched.
- `abort` during run 1 (run 0 fitness=4) → FINISH, `best_fitness`=4, `seq_done`=1, `busy`=0, and no third `hc_start`.
- `start_req` while `busy` is ignored. `hc_clk_enable` shows a period of 4 cycles with a high width of 1.
- `rst_n` low during RUN → all outputs 0 immediately. A new `start_req` after release behaves as in the first scenario.
